// File: rtl/sram_sp_mask_init_ext.sv
// Single-port SRAM model with per-lane write mask and a zero-fill sweep after reset.
// Latency: read data and rvalid READ_LATENCY posedges after the accepting edge; writes land on that edge.
// Backpressure: ready is low during reset and the init sweep; requests made then are dropped.
module sram_sp_mask_init_ext #(
    parameter int DEPTH         = 512,
    parameter int WIDTH         = 16,
    parameter int MASK_GRAN     = 8,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1,
    parameter int HOLD_RDATA    = 1,
    localparam int AW           = $clog2(DEPTH),
    localparam int LANES        = WIDTH / MASK_GRAN
) (
    input  logic               RW0_clk,
    input  logic               RW0_reset,
    input  logic [AW-1:0]      RW0_addr,
    input  logic               RW0_en,
    input  logic               RW0_wmode,
    input  logic [LANES-1:0]   RW0_wmask,
    input  logic [WIDTH-1:0]   RW0_wdata,
    output logic [WIDTH-1:0]   RW0_rdata,
    output logic               RW0_rvalid,
    output logic               RW0_ready
);

    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0]        ram [DEPTH];
    state_t                  state_q;
    state_t                  state_nxt;
    logic [AW-1:0]           init_cnt;
    logic                    init_we;
    logic                    addr_ok;
    logic                    acc;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [AW-1:0]           rd_addr_q;
    logic                    rd_ok_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]        rd_dat0;
    logic [WIDTH-1:0]        pipe_dat;
    logic                    pipe_vld;
    logic [WIDTH-1:0]        hold_q;

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (state_q == ST_INIT && init_cnt == LAST) begin
            state_nxt = ST_READY;
        end
    end

    always_comb begin
        RW0_ready = (state_q == ST_READY) && !RW0_reset;
        init_we   = (state_q == ST_INIT) && !RW0_reset;
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            init_cnt <= '0;
        end else if (init_we) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign addr_ok = {1'b0, RW0_addr} < DEPTH_W;
    assign acc     = RW0_en && RW0_ready;
    assign wr_acc  = acc && RW0_wmode;
    assign rd_acc  = acc && !RW0_wmode;

    always_ff @(posedge RW0_clk) begin
        if (init_we) begin
            ram[init_cnt] <= '0;
        end else if (wr_acc && addr_ok) begin
            for (int k = 0; k < LANES; k++) begin
                if (RW0_wmask[k]) begin
                    ram[RW0_addr][k*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (rd_acc) begin
            rd_addr_q <= RW0_addr;
            rd_ok_q   <= addr_ok;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign rd_dat0  = rd_ok_q ? ram[rd_addr_q] : '0;
    assign pipe_vld = vld_q[READ_LATENCY-1];

    // Data stages carry no reset; the valid chain alone qualifies them.
    if (READ_LATENCY == 1) begin : g_lat1
        assign pipe_dat = rd_dat0;
    end else begin : g_latn
        logic [WIDTH-1:0] dat_q [1:READ_LATENCY-1];
        always_ff @(posedge RW0_clk) begin
            dat_q[1] <= rd_dat0;
            for (int i = 2; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
        end
        assign pipe_dat = dat_q[READ_LATENCY-1];
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            hold_q <= '0;
        end else if (pipe_vld) begin
            hold_q <= pipe_dat;
        end
    end

    always_comb begin
        RW0_rvalid = pipe_vld && !RW0_reset;
        RW0_rdata  = '0;
        if (!RW0_reset) begin
            if (pipe_vld) begin
                RW0_rdata = pipe_dat;
            end else if (HOLD_RDATA != 0) begin
                RW0_rdata = hold_q;
            end
        end
    end

endmodule

// File: tb/tb_sram_sp_mask_init_ext.sv
// Bench for sram_sp_mask_init_ext: instance 0 uses defaults, instance 1 is a
// 320-deep, latency-3, non-holding variant; both track a scoreboard memory model.
module tb_sram_sp_mask_init_ext;

    typedef struct packed {
        logic        en;
        logic        wm;
        logic [8:0]  a;
        logic [1:0]  m;
        logic [15:0] d;
    } op_t;

    logic        clk;
    logic        rst_i  [2];
    logic        en_i   [2];
    logic        wm_i   [2];
    logic [8:0]  addr_i [2];
    logic [1:0]  mask_i [2];
    logic [15:0] wd_i   [2];
    logic [15:0] a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid, a_ready, b_ready;

    logic        obs_rdy [2];
    logic        obs_vld [2];
    logic [15:0] obs_dat [2];
    logic        exp_rdy [2];
    logic        exp_vld [2];
    logic [15:0] exp_dat [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int depth_c [2] = '{512, 320};
    int lat_c   [2] = '{1, 3};
    int hold_c  [2] = '{1, 0};

    logic [15:0] mem     [2][512];
    bit          m_ready [2];
    int          m_init  [2];
    bit          sv      [2][8];
    logic [15:0] sd      [2][8];
    logic [15:0] m_hold  [2];

    sram_sp_mask_init_ext dut_a (
        .RW0_clk   (clk),
        .RW0_reset (rst_i[0]),
        .RW0_addr  (addr_i[0]),
        .RW0_en    (en_i[0]),
        .RW0_wmode (wm_i[0]),
        .RW0_wmask (mask_i[0]),
        .RW0_wdata (wd_i[0]),
        .RW0_rdata (a_rdata),
        .RW0_rvalid(a_rvalid),
        .RW0_ready (a_ready)
    );

    sram_sp_mask_init_ext #(
        .DEPTH(320), .READ_LATENCY(3), .HOLD_RDATA(0)
    ) dut_b (
        .RW0_clk   (clk),
        .RW0_reset (rst_i[1]),
        .RW0_addr  (addr_i[1]),
        .RW0_en    (en_i[1]),
        .RW0_wmode (wm_i[1]),
        .RW0_wmask (mask_i[1]),
        .RW0_wdata (wd_i[1]),
        .RW0_rdata (b_rdata),
        .RW0_rvalid(b_rvalid),
        .RW0_ready (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic apply(input int i, input op_t o);
        en_i[i]   = o.en;
        wm_i[i]   = o.wm;
        addr_i[i] = o.a;
        mask_i[i] = o.m;
        wd_i[i]   = o.d;
    endtask

    // One clock: update the scoreboard with the inputs seen at this edge, then sample outputs.
    task automatic step();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int s;
            int d;
            s = cyc % 8;
            if (rst_i[i]) begin
                m_ready[i] = 1'b0;
                m_init[i]  = 0;
                m_hold[i]  = 16'h0;
                for (int j = 0; j < 8; j++) sv[i][j] = 1'b0;
            end else if (!m_ready[i]) begin
                mem[i][m_init[i]] = 16'h0;
                m_init[i]++;
                if (m_init[i] == depth_c[i]) m_ready[i] = 1'b1;
            end else if (en_i[i]) begin
                if (wm_i[i]) begin
                    if (int'(addr_i[i]) < depth_c[i]) begin
                        for (int k = 0; k < 2; k++)
                            if (mask_i[i][k]) mem[i][addr_i[i]][k*8 +: 8] = wd_i[i][k*8 +: 8];
                    end
                end else begin
                    d = (cyc + lat_c[i] - 1) % 8;
                    sv[i][d] = 1'b1;
                    sd[i][d] = (int'(addr_i[i]) < depth_c[i]) ? mem[i][addr_i[i]] : 16'h0;
                end
            end
            exp_rdy[i] = m_ready[i] && !rst_i[i];
            if (rst_i[i]) begin
                exp_vld[i] = 1'b0;
                exp_dat[i] = 16'h0;
            end else if (sv[i][s]) begin
                exp_vld[i] = 1'b1;
                exp_dat[i] = sd[i][s];
                m_hold[i]  = sd[i][s];
                sv[i][s]   = 1'b0;
            end else begin
                exp_vld[i] = 1'b0;
                exp_dat[i] = (hold_c[i] != 0) ? m_hold[i] : 16'h0;
            end
        end
        @(negedge clk);
        obs_rdy[0] = a_ready;  obs_vld[0] = a_rvalid;  obs_dat[0] = a_rdata;
        obs_rdy[1] = b_ready;  obs_vld[1] = b_rvalid;  obs_dat[1] = b_rdata;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b1;
            apply(i, '0);
        end
        for (int n = 0; n < 3; n++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== 1'b0 || obs_vld[i] !== 1'b0 || obs_dat[i] !== 16'h0) begin
                    errors++;
                    $display("FAIL reset inst%0d: rdy=%b vld=%b dat=%h expected 0 0 0000",
                             i, obs_rdy[i], obs_vld[i], obs_dat[i]);
                end
            end
        end
    endtask

    task automatic test_init_sweep();
        int first [2];
        first = '{-1, -1};
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;
        for (int n = 1; n <= 520; n++) begin
            for (int i = 0; i < 2; i++)
                apply(i, (n == 10) ? op_t'{1'b1, 1'b1, 9'd7, 2'b11, 16'hFFFF} : op_t'('0));
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== exp_rdy[i] || obs_vld[i] !== exp_vld[i] || obs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL init_sweep inst%0d edge%0d: rdy=%b vld=%b dat=%h expected %b %b %h",
                             i, n, obs_rdy[i], obs_vld[i], obs_dat[i], exp_rdy[i], exp_vld[i], exp_dat[i]);
                end
                if (obs_rdy[i] === 1'b1 && first[i] < 0) first[i] = n;
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (first[i] != depth_c[i]) begin
                errors++;
                $display("FAIL ready_edge inst%0d: ready first at edge %0d expected %0d", i, first[i], depth_c[i]);
            end
        end
    endtask

    task automatic test_read_after_init();
        op_t ops [2][6];
        int  nv  [2];
        ops[0] = '{'{1'b1, 1'b0, 9'h1FF, 2'b00, 16'h0}, '{1'b1, 1'b0, 9'd7, 2'b00, 16'h0},
                   '0, '0, '0, '0};
        ops[1] = '{'{1'b1, 1'b0, 9'd319, 2'b00, 16'h0}, '{1'b1, 1'b0, 9'd7, 2'b00, 16'h0},
                   '0, '0, '0, '0};
        nv = '{0, 0};
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 2; i++) apply(i, ops[i][n]);
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== exp_rdy[i] || obs_vld[i] !== exp_vld[i] || obs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL read_zero inst%0d n%0d: rdy=%b vld=%b dat=%h expected %b %b %h",
                             i, n, obs_rdy[i], obs_vld[i], obs_dat[i], exp_rdy[i], exp_vld[i], exp_dat[i]);
                end
                if (obs_vld[i] === 1'b1) begin
                    nv[i]++;
                    checks++;
                    if (obs_dat[i] !== 16'h0) begin
                        errors++;
                        $display("FAIL read_zero_dat inst%0d: dat=%h expected 0000", i, obs_dat[i]);
                    end
                end
            end
            if (n == 0) begin
                checks++;
                if (obs_vld[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL read_lat1 inst0: rvalid=%b expected 1 one edge after accept", obs_vld[0]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nv[i] != 2) begin
                errors++;
                $display("FAIL read_zero_count inst%0d: %0d rvalids expected 2", i, nv[i]);
            end
        end
    endtask

    task automatic test_mask();
        op_t ops [9];
        int  nv  [2];
        ops = '{'{1'b1, 1'b1, 9'd5, 2'b11, 16'hABCD}, '{1'b1, 1'b1, 9'd5, 2'b01, 16'h1234},
                '{1'b1, 1'b0, 9'd5, 2'b00, 16'h0},    '{1'b1, 1'b1, 9'd5, 2'b00, 16'hFFFF},
                '{1'b1, 1'b0, 9'd5, 2'b00, 16'h0},    '0, '0, '0, '0};
        nv = '{0, 0};
        for (int n = 0; n < 9; n++) begin
            for (int i = 0; i < 2; i++) apply(i, ops[n]);
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== exp_rdy[i] || obs_vld[i] !== exp_vld[i] || obs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL mask inst%0d n%0d: rdy=%b vld=%b dat=%h expected %b %b %h",
                             i, n, obs_rdy[i], obs_vld[i], obs_dat[i], exp_rdy[i], exp_vld[i], exp_dat[i]);
                end
                if (obs_vld[i] === 1'b1) begin
                    nv[i]++;
                    checks++;
                    if (obs_dat[i] !== 16'hAB34) begin
                        errors++;
                        $display("FAIL mask_dat inst%0d: dat=%h expected ab34", i, obs_dat[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nv[i] != 2) begin
                errors++;
                $display("FAIL mask_count inst%0d: %0d rvalids expected 2", i, nv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t        ops [13];
        logic [9:0] vec [2];
        int         idx [2];
        ops = '{'{1'b1, 1'b1, 9'd1, 2'b11, 16'h0011}, '{1'b1, 1'b1, 9'd2, 2'b11, 16'h0022},
                '{1'b1, 1'b1, 9'd3, 2'b11, 16'h0033}, '{1'b1, 1'b0, 9'd1, 2'b00, 16'h0},
                '{1'b1, 1'b0, 9'd2, 2'b00, 16'h0},    '{1'b1, 1'b0, 9'd3, 2'b00, 16'h0},
                '0, '0, '0, '0, '0, '0, '0};
        vec = '{10'h0, 10'h0};
        idx = '{0, 0};
        for (int n = 0; n < 13; n++) begin
            for (int i = 0; i < 2; i++) apply(i, ops[n]);
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== exp_rdy[i] || obs_vld[i] !== exp_vld[i] || obs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL b2b inst%0d n%0d: rdy=%b vld=%b dat=%h expected %b %b %h",
                             i, n, obs_rdy[i], obs_vld[i], obs_dat[i], exp_rdy[i], exp_vld[i], exp_dat[i]);
                end
                if (n >= 3) vec[i][n-3] = obs_vld[i];
                if (obs_vld[i] === 1'b1) begin
                    checks++;
                    if (obs_dat[i] !== 16'(16'h0011 * (idx[i] + 1))) begin
                        errors++;
                        $display("FAIL b2b_order inst%0d #%0d: dat=%h expected %h",
                                 i, idx[i], obs_dat[i], 16'(16'h0011 * (idx[i] + 1)));
                    end
                    idx[i]++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (vec[i] !== 10'(10'b111 << (lat_c[i] - 1))) begin
                errors++;
                $display("FAIL b2b_timing inst%0d: rvalid pattern %b expected %b",
                         i, vec[i], 10'(10'b111 << (lat_c[i] - 1)));
            end
        end
    endtask

    task automatic test_reset_midread();
        int first [2];
        bit late_vld;
        first = '{-1, -1};
        late_vld = 1'b0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 2; i++)
                apply(i, (n == 0) ? op_t'{1'b1, 1'b1, 9'd9, 2'b11, 16'hAB34}
                                  : op_t'{1'b1, 1'b0, 9'd9, 2'b00, 16'h0});
            step();
        end
        for (int n = 0; n < 524; n++) begin
            for (int i = 0; i < 2; i++) begin
                rst_i[i] = (n < 2);
                apply(i, '0);
            end
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== exp_rdy[i] || obs_vld[i] !== exp_vld[i] || obs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL midread inst%0d n%0d: rdy=%b vld=%b dat=%h expected %b %b %h",
                             i, n, obs_rdy[i], obs_vld[i], obs_dat[i], exp_rdy[i], exp_vld[i], exp_dat[i]);
                end
                if (n >= 2 && obs_rdy[i] === 1'b1 && first[i] < 0) first[i] = n - 1;
            end
            if (obs_vld[1] !== 1'b0) late_vld = 1'b1;
        end
        checks++;
        if (late_vld) begin
            errors++;
            $display("FAIL midread_discard inst1: rvalid seen for a read cut by reset, expected none");
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (first[i] != depth_c[i]) begin
                errors++;
                $display("FAIL resweep inst%0d: ready at edge %0d after release expected %0d",
                         i, first[i], depth_c[i]);
            end
        end
    endtask

    task automatic test_hold();
        bit seen [2];
        seen = '{1'b0, 1'b0};
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 2; i++)
                apply(i, (n == 0) ? op_t'{1'b1, 1'b1, 9'd5, 2'b11, 16'hAB34} :
                         (n == 1) ? op_t'{1'b1, 1'b0, 9'd5, 2'b00, 16'h0} : op_t'('0));
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== exp_rdy[i] || obs_vld[i] !== exp_vld[i] || obs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL hold inst%0d n%0d: rdy=%b vld=%b dat=%h expected %b %b %h",
                             i, n, obs_rdy[i], obs_vld[i], obs_dat[i], exp_rdy[i], exp_vld[i], exp_dat[i]);
                end
                if (seen[i] && obs_vld[i] === 1'b0) begin
                    checks++;
                    if (obs_dat[i] !== ((hold_c[i] != 0) ? 16'hAB34 : 16'h0)) begin
                        errors++;
                        $display("FAIL hold_idle inst%0d: dat=%h expected %h",
                                 i, obs_dat[i], (hold_c[i] != 0) ? 16'hAB34 : 16'h0);
                    end
                end
                if (obs_vld[i] === 1'b1) seen[i] = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        op_t o;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                o.en = 1'($urandom_range(0, 3) != 0);
                o.wm = 1'($urandom_range(0, 1));
                o.m  = 2'($urandom_range(0, 3));
                o.d  = 16'($urandom);
                if (i == 1 && $urandom_range(0, 3) == 0) o.a = 9'(316 + $urandom_range(0, 14));
                else                                     o.a = 9'($urandom_range(0, 15));
                apply(i, o);
            end
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdy[i] !== exp_rdy[i] || obs_vld[i] !== exp_vld[i] || obs_dat[i] !== exp_dat[i]) begin
                    errors++;
                    $display("FAIL random inst%0d n%0d: rdy=%b vld=%b dat=%h expected %b %b %h",
                             i, n, obs_rdy[i], obs_vld[i], obs_dat[i], exp_rdy[i], exp_vld[i], exp_dat[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_read_after_init();
        test_mask();
        test_back_to_back();
        test_reset_midread();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_sp_mask_init_ext.md
Name: sram_sp_mask_init_ext

Overview:
Parametrised single-port SRAM behavioural model, the next generation of the fixed 512x16 single-port array macro. Adds a per-lane write mask, configurable read latency with a read-valid strobe, and a hardware zero-initialisation sweep after reset. It sits behind cache and predictor tables that need known-zero contents and deeper read pipelines without per-size macro files.

Parameters:
DEPTH, 512, number of words; >= 2.
WIDTH, 16, data bits per word.
MASK_GRAN, 8, bits per write-mask lane; WIDTH % MASK_GRAN == 0.
READ_LATENCY, 1, posedges from read accept to rdata valid; legal range 1..4.
INIT_ON_RESET, 1, 1 = zero-fill every word after reset; 0 = no sweep, contents undefined.
HOLD_RDATA, 1, 1 = rdata holds the last valid read; 0 = rdata is 0 when rvalid is low.

Ports:
RW0_clk  in  1  clock; all logic on posedge.
RW0_reset  in  1  synchronous active-high reset.
RW0_addr  in  AW = clog2(DEPTH)  word address.
RW0_en  in  1  request strobe.
RW0_wmode  in  1  1 = write, 0 = read.
RW0_wmask  in  WIDTH/MASK_GRAN  write lane enables; bit k covers data bits [k*MASK_GRAN +: MASK_GRAN].
RW0_wdata  in  WIDTH  write data.
RW0_rdata  out  WIDTH  read data.
RW0_rvalid  out  1  one-cycle strobe; rdata is valid when high.
RW0_ready  out  1  array is accepting requests.

Behaviour:
- Reset: one clock, RW0_clk; reset RW0_reset is synchronous and active-high. While reset is high: RW0_ready=0, RW0_rvalid=0, RW0_rdata=0, read pipeline valids cleared, init counter=0. State goes to INIT if INIT_ON_RESET=1, else READY. Memory contents are not touched by reset itself.
- RW0_ready = (state==READY) && !RW0_reset.
- FSM states:
  - INIT: each posedge with reset low writes WIDTH'b0 to ram[cnt] and increments cnt. The edge that writes DEPTH-1 moves to READY. The first edge after reset release writes address 0, so ready is seen high after exactly DEPTH edges.
  - READY: terminal state until the next reset.
- Accept: a request is accepted at a posedge when RW0_en && RW0_ready. When not accepted (INIT, reset), the request is dropped silently: no write, no rvalid, no queuing.
- Write accept (wmode=1): for every lane k with wmask[k]=1, that lane of ram[addr] takes the corresponding wdata lane at the same edge. Unmasked lanes keep their value. wmask=0 is a legal no-op write. No rvalid is produced.
- Read accept (wmode=0):
  - Address is registered at the accept edge and ram is read from the registered address.
  - Data passes through READ_LATENCY-1 further data registers.
  - RW0_rvalid is high for exactly one cycle, READ_LATENCY edges after the accept edge, with the matching rdata.
  - Fully pipelined: one read per cycle sustains continuous rvalid, in order.
- Write-then-read: a read accepted the cycle after a write to the same address returns the new data. Single port, so there is no same-cycle read/write hazard.
- rdata when rvalid is low: holds the last valid value if HOLD_RDATA=1, else 0. After reset it is 0 until the first rvalid.
- Reset mid-operation: in-flight reads are discarded (rvalid never asserts for them). A reset during INIT restarts the sweep at address 0. Writes are never partially applied; a write edge coinciding with reset is not performed.
- Addresses >= DEPTH (non-power-of-2 DEPTH) are ignored for writes; reads return 0 with normal rvalid timing.
- No randomisation or garbage-assign modes; outputs are deterministic.

Test Plan:
1. Defaults, hold reset 3 cycles, release → ready low for 512 edges then high; read 0x1FF → rvalid one cycle later, rdata=0x0000.
2. Write addr 5, 0xABCD, mask 2'b11; write addr 5, 0x1234, mask 2'b01; read 5 → rdata=0xAB34. Then write with mask 2'b00 and read → still 0xAB34.
3. READ_LATENCY=3, write 0x0011/0x0022/0x0033 to addrs 1/2/3; issue reads 1,2,3 on consecutive cycles → rvalid high on edges +3,+4,+5, data 0x0011,0x0022,0x0033; rvalid low otherwise.
4. During INIT, drive en=1, wmode=1, addr 7, data 0xFFFF at cycle 10 after release → no rvalid. After ready, read 7 → 0x0000.
5. READ_LATENCY=3, accept read of 0xAB34 word, assert reset on the next edge → rvalid stays 0, rdata=0, ready drops and the sweep restarts (ready high 512 edges after release).
6. HOLD_RDATA=1: read returning 0xAB34 then idle → rdata stays 0xAB34. HOLD_RDATA=0: same stimulus → rdata=0x0000 on the cycle after the rvalid cycle.
